mem_arbiter: RTL and testbench

Single-port memory arbiter for the pipelined MIPS processor. It shares one unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store). It grants one access at a time, sequences the fixed-latency memory transaction, and drives per-requester stall signals that the hazard unit ORs into the pipeline freeze.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one unified instruction/data memory between the IF stage
//             (fetch) and the MEM stage (load/store). Grants one access at a
//             time, sequences a fixed-latency memory transaction and drives
//             per-requester stall signals for the hazard unit.
//  Ports    :
//    clk, reset                 clock, asynchronous active-low reset
//    if_req/if_addr             fetch request (held until if_valid)
//    if_stall/if_rdata/if_valid fetch status, fetched word, completion pulse
//    dm_req/dm_we/dm_addr/
//    dm_wdata                   data request (held until dm_valid)
//    dm_stall/dm_rdata/dm_valid data status, load result, completion pulse
//    mem_en/mem_we/mem_addr/
//    mem_wdata/mem_rdata        memory side; read data arrives MEM_LAT
//                               cycles after the mem_en cycle
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2     // legal range 1..15 (4-bit counter)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_stall,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);
  localparam logic       GNT_IF   = 1'b0;   // 1'b1 selects the data port

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       gnt;        // requester owning the current access
  logic       last;       // most recent grant, used to break ties
  logic       cap_we;     // captured write enable of the current access
  logic [3:0] cnt;

  logic any_req;
  logic pick;
  logic grant_now;
  logic last_wait;

  // On a tie the requester that did not win last time is chosen; otherwise
  // the single active requester wins (dm_req=0 here implies IF).
  assign any_req   = if_req | dm_req;
  assign pick      = (if_req & dm_req) ? ~last : dm_req;
  assign grant_now = (state == ST_IDLE) & any_req;
  // Read data is valid during the WAIT cycle whose counter reads 1.
  assign last_wait = (state == ST_WAIT) & (cnt <= 4'd1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req)   state_nxt = ST_ISSUE;
      ST_ISSUE:                state_nxt = ST_WAIT;
      ST_WAIT:  if (last_wait) state_nxt = ST_DONE;
      // Requests seen at the DONE edge belong to the access being retired.
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, captured access, latency counter and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= GNT_IF;
      last      <= GNT_IF;
      cap_we    <= 1'b0;
      cnt       <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if (grant_now) begin
        gnt  <= pick;
        last <= pick;
        if (pick == GNT_IF) begin
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          cap_we    <= 1'b0;
        end else begin
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          cap_we    <= dm_we;
        end
      end

      // Reloaded only in ISSUE, so the counter never wraps.
      if (state == ST_ISSUE) begin
        cnt <= LAT_LOAD;
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      // A store leaves dm_rdata untouched.
      if (last_wait) begin
        if (gnt == GNT_IF) begin
          if_rdata <= mem_rdata;
        end else if (!cap_we) begin
          dm_rdata <= mem_rdata;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    mem_en   = (state == ST_ISSUE);
    mem_we   = (state == ST_ISSUE) & cap_we;
    if_valid = (state == ST_DONE) & (gnt == GNT_IF);
    dm_valid = (state == ST_DONE) & (gnt != GNT_IF);
    if_stall = if_req & ~if_valid;
    dm_stall = dm_req & ~dm_valid;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. Directed cycle tables,
//             a grant-alternation sequence, latency extremes (1 and 15) and
//             a randomized run against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam logic [31:0] DC  = 32'hDCDC_DCDC;   // "don't care" marker
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;
  localparam logic [31:0] FD  = 32'h0BAD_F00D;
  localparam logic [31:0] D55 = 32'h5555_AAAA;
  localparam logic [31:0] AA  = 32'hAAAA_0000;
  localparam logic [31:0] SW  = 32'h1234_5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_stall, if_valid, dm_stall, dm_valid, mem_en, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_stall(dm_stall), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- memory model (word index = addr[9:2]) ----------------
  bit          wr   [256];
  logic [31:0] wmem [256];
  bit          pv   [16];
  logic [31:0] pd   [16];

  function automatic logic [31:0] base(int i);
    case (i)
      4:       return DB;
      8:       return FD;
      16:      return D55;
      32:      return AA;
      default: return (32'(i) * 32'h0101_0101) ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic logic [31:0] rd(logic [31:0] a);
    return wr[a[9:2]] ? wmem[a[9:2]] : base(int'(a[9:2]));
  endfunction

  // Read data appears exactly LAT cycles after the mem_en cycle; any other
  // cycle shows a junk word so mistimed captures are visible.
  always @(posedge clk) begin
    pv[0] <= mem_en & ~mem_we;
    pd[0] <= rd(mem_addr);
    for (int i = 1; i < 16; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    if (mem_en && mem_we) begin
      wr[mem_addr[9:2]]   <= 1'b1;
      wmem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'h0BAD_0BAD;

  // ---------------- latency-extreme instances (1 and 15) ----------------
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_x
      localparam int L = (g == 0) ? 1 : 15;
      logic        req = 1'b0;
      logic        stall, valid, dstall, dvalid, en, we;
      logic [31:0] rdata, drdata, maddr, mwdata, mrdata;
      int          age = 0;
      mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_lat (
        .clk(clk), .reset(reset),
        .if_req(req), .if_addr(32'h0000_0100), .if_stall(stall),
        .if_rdata(rdata), .if_valid(valid),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_stall(dstall), .dm_rdata(drdata), .dm_valid(dvalid),
        .mem_en(en), .mem_we(we), .mem_addr(maddr),
        .mem_wdata(mwdata), .mem_rdata(mrdata)
      );
      always @(posedge clk) begin
        if (en) age <= 1;
        else if (age != 0 && age < 64) age <= age + 1;
      end
      assign mrdata = (age == L) ? (32'hC0DE_0000 + 32'(L)) : 32'h0;
    end
  endgenerate

  // ---------------- checking helpers ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (exp == DC) return;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, ifr; logic [31:0] ifa;
    logic dmr, dmw; logic [31:0] dma, dmd;
    logic en, we;   logic [31:0] ma, mwd;
    logic ifv, ifs; logic [31:0] ifd;
    logic dmv, dms; logic [31:0] dmo;
  } vec_t;

  function automatic vec_t mk(logic r, logic ifr, logic [31:0] ifa, logic dmr, logic dmw,
                              logic [31:0] dma, logic [31:0] dmd, logic en, logic we,
                              logic [31:0] ma, logic [31:0] mwd, logic ifv, logic ifs,
                              logic [31:0] ifd, logic dmv, logic dms, logic [31:0] dmo);
    vec_t v;
    v.rst = r;   v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dmw = dmw; v.dma = dma;
    v.dmd = dmd; v.en = en;   v.we = we;   v.ma = ma;   v.mwd = mwd; v.ifv = ifv;
    v.ifs = ifs; v.ifd = ifd; v.dmv = dmv; v.dms = dms; v.dmo = dmo;
    return v;
  endfunction

  task automatic apply(vec_t v);
    reset = v.rst; if_req = v.ifr; if_addr = v.ifa;
    dm_req = v.dmr; dm_we = v.dmw; dm_addr = v.dma; dm_wdata = v.dmd;
  endtask

  task automatic check_row(vec_t v, int k);
    chk($sformatf("v%0d mem_en", k),    32'(mem_en),   32'(v.en));
    chk($sformatf("v%0d mem_we", k),    32'(mem_we),   32'(v.we));
    chk($sformatf("v%0d mem_addr", k),  mem_addr,      v.ma);
    chk($sformatf("v%0d mem_wdata", k), mem_wdata,     v.mwd);
    chk($sformatf("v%0d if_valid", k),  32'(if_valid), 32'(v.ifv));
    chk($sformatf("v%0d if_stall", k),  32'(if_stall), 32'(v.ifs));
    chk($sformatf("v%0d if_rdata", k),  if_rdata,      v.ifd);
    chk($sformatf("v%0d dm_valid", k),  32'(dm_valid), 32'(v.dmv));
    chk($sformatf("v%0d dm_stall", k),  32'(dm_stall), 32'(v.dms));
    chk($sformatf("v%0d dm_rdata", k),  dm_rdata,      v.dmo);
  endtask

  int          first [2];
  int          ens   [2];
  int          dvs   [2];
  logic [31:0] got   [2];

  task automatic samp(int k, int c, logic en, logic v, logic [31:0] d, logic dv);
    if (en) ens[k]++;
    if (dv) dvs[k]++;
    if (v && first[k] < 0) begin
      first[k] = c;
      got[k]   = d;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t q[$];
    vec_t rr;
    int   order[$];
    logic pifv, pdmv;
    // reference model state
    int   ph;
    logic own, lst, cwe, e_ifv, e_dmv;
    logic [31:0] caddr, cwd, cdat, eifd, edmd;

    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(posedge clk);

    rr = mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0);   // reset cycle
    // single fetch from 0x10
    q.push_back(rr);
    q.push_back(mk(1,1,'h10,0,0,0,0, 0,0,0,0,     0,1,0,  0,0,0));
    q.push_back(mk(1,1,'h10,0,0,0,0, 1,0,'h10,DC, 0,1,0,  0,0,0));
    q.push_back(mk(1,1,'h10,0,0,0,0, 0,0,'h10,DC, 0,1,0,  0,0,0));
    q.push_back(mk(1,1,'h10,0,0,0,0, 0,0,'h10,DC, 0,1,0,  0,0,0));
    q.push_back(mk(1,1,'h10,0,0,0,0, 0,0,'h10,DC, 1,0,DB, 0,0,0));
    q.push_back(mk(1,0,'h10,0,0,0,0, 0,0,DC,DC,   0,0,DB, 0,0,0));
    // simultaneous requests right after reset: DM first, then IF
    q.push_back(rr);
    q.push_back(mk(1,1,'h20,1,0,'h40,0, 0,0,0,0,     0,1,0,  0,1,0));
    q.push_back(mk(1,1,'h20,1,0,'h40,0, 1,0,'h40,DC, 0,1,0,  0,1,0));
    q.push_back(mk(1,1,'h20,1,0,'h40,0, 0,0,'h40,DC, 0,1,0,  0,1,0));
    q.push_back(mk(1,1,'h20,1,0,'h40,0, 0,0,'h40,DC, 0,1,0,  0,1,0));
    q.push_back(mk(1,1,'h20,1,0,'h40,0, 0,0,'h40,DC, 0,1,0,  1,0,D55));
    q.push_back(mk(1,1,'h20,0,0,'h40,0, 0,0,DC,DC,   0,1,0,  0,0,D55));
    q.push_back(mk(1,1,'h20,0,0,'h40,0, 1,0,'h20,DC, 0,1,0,  0,0,D55));
    q.push_back(mk(1,1,'h20,0,0,'h40,0, 0,0,'h20,DC, 0,1,0,  0,0,D55));
    q.push_back(mk(1,1,'h20,0,0,'h40,0, 0,0,'h20,DC, 0,1,0,  0,0,D55));
    q.push_back(mk(1,1,'h20,0,0,'h40,0, 0,0,'h20,DC, 1,0,FD, 0,0,D55));
    q.push_back(mk(1,0,'h20,0,0,'h40,0, 0,0,DC,DC,   0,0,FD, 0,0,D55));
    // load 0x80 (gives 0xAAAA0000), then store 0x12345678 to 0x80
    q.push_back(rr);
    q.push_back(mk(1,0,0,1,0,'h80,0,  0,0,0,0,     0,0,0, 0,1,0));
    q.push_back(mk(1,0,0,1,0,'h80,0,  1,0,'h80,DC, 0,0,0, 0,1,0));
    q.push_back(mk(1,0,0,1,0,'h80,0,  0,0,'h80,DC, 0,0,0, 0,1,0));
    q.push_back(mk(1,0,0,1,0,'h80,0,  0,0,'h80,DC, 0,0,0, 0,1,0));
    q.push_back(mk(1,0,0,1,0,'h80,0,  0,0,'h80,DC, 0,0,0, 1,0,AA));
    q.push_back(mk(1,0,0,0,0,'h80,0,  0,0,DC,DC,   0,0,0, 0,0,AA));
    q.push_back(mk(1,0,0,1,1,'h80,SW, 0,0,DC,DC,   0,0,0, 0,1,AA));
    q.push_back(mk(1,0,0,1,1,'h80,SW, 1,1,'h80,SW, 0,0,0, 0,1,AA));
    q.push_back(mk(1,0,0,1,1,'h80,SW, 0,0,'h80,SW, 0,0,0, 0,1,AA));
    q.push_back(mk(1,0,0,1,1,'h80,SW, 0,0,'h80,SW, 0,0,0, 0,1,AA));
    q.push_back(mk(1,0,0,1,1,'h80,SW, 0,0,'h80,SW, 0,0,0, 1,0,AA));
    q.push_back(mk(1,0,0,0,0,'h80,0,  0,0,DC,DC,   0,0,0, 0,0,AA));
    // reset asserted in WAIT of a fetch, then a fresh grant
    q.push_back(rr);
    q.push_back(mk(1,1,'h10,0,0,0,0, 0,0,0,0,     0,1,0,  0,0,0));
    q.push_back(mk(1,1,'h10,0,0,0,0, 1,0,'h10,DC, 0,1,0,  0,0,0));
    q.push_back(mk(0,1,'h10,0,0,0,0, 0,0,0,0,     0,1,0,  0,0,0));
    q.push_back(mk(1,1,'h10,0,0,0,0, 0,0,0,0,     0,1,0,  0,0,0));
    q.push_back(mk(1,1,'h10,0,0,0,0, 1,0,'h10,DC, 0,1,0,  0,0,0));
    q.push_back(mk(1,1,'h10,0,0,0,0, 0,0,'h10,DC, 0,1,0,  0,0,0));
    q.push_back(mk(1,1,'h10,0,0,0,0, 0,0,'h10,DC, 0,1,0,  0,0,0));
    q.push_back(mk(1,1,'h10,0,0,0,0, 0,0,'h10,DC, 1,0,DB, 0,0,0));
    q.push_back(mk(1,0,'h10,0,0,0,0, 0,0,DC,DC,   0,0,DB, 0,0,0));

    for (int k = 0; k < q.size(); k++) begin
      @(posedge clk); #1;
      apply(q[k]);
      @(negedge clk);
      check_row(q[k], k);
    end

    // ---- both requesters busy, each drops for one cycle after its valid ----
    pulse_reset();
    pifv = 1'b0; pdmv = 1'b0;
    if_addr = 32'h0000_0010; dm_addr = 32'h0000_0040; dm_we = 1'b0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      if_req = !pifv;
      dm_req = !pdmv;
      @(negedge clk);
      if (if_valid && dm_valid) chk("alt both valid", 32'd1, 32'd0);
      if (dm_valid) order.push_back(1);
      if (if_valid) order.push_back(0);
      pifv = if_valid; pdmv = dm_valid;
      @(posedge clk); #1;
    end
    chk("alt count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++)
      chk($sformatf("alt grant%0d", i), 32'(order[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

    // ---- latency extremes: MEM_LAT=1 and MEM_LAT=15 ----
    if_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      first[k] = -1; ens[k] = 0; dvs[k] = 0; got[k] = '0;
    end
    g_x[0].req = 1'b1;
    g_x[1].req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      samp(0, c, g_x[0].en, g_x[0].valid, g_x[0].rdata, g_x[0].dvalid);
      samp(1, c, g_x[1].en, g_x[1].valid, g_x[1].rdata, g_x[1].dvalid);
      @(posedge clk); #1;
      if (first[0] >= 0) g_x[0].req = 1'b0;
      if (first[1] >= 0) g_x[1].req = 1'b0;
    end
    chk("lat1 valid cycle",  32'(first[0]), 32'd3);
    chk("lat15 valid cycle", 32'(first[1]), 32'd17);
    chk("lat1 mem_en count", 32'(ens[0]), 32'd1);
    chk("lat15 mem_en count", 32'(ens[1]), 32'd1);
    chk("lat1 rdata",  got[0], 32'hC0DE_0001);
    chk("lat15 rdata", got[1], 32'hC0DE_000F);
    chk("lat dm_valid pulses", 32'(dvs[0] + dvs[1]), 32'd0);

    // ---- randomized traffic against a phase-counting transaction model ----
    pulse_reset();
    ph = 0; own = 1'b0; lst = 1'b0; cwe = 1'b0;
    caddr = '0; cwd = '0; cdat = '0; eifd = '0; edmd = '0;
    e_ifv = 1'b0; e_dmv = 1'b0;
    for (int c = 0; c < 600; c++) begin
      // requesters hold until completion, then decide afresh
      if (!if_req || e_ifv) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom & 32'hFFFF_007C;
      end
      if (!dm_req || e_dmv) begin
        dm_req   = 1'($urandom_range(0, 1));
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = $urandom & 32'hFFFF_007C;
        dm_wdata = $urandom;
      end
      @(negedge clk);
      e_ifv = (ph == LAT + 2) && !own;
      e_dmv = (ph == LAT + 2) && own;
      chk($sformatf("rnd%0d mem_en", c),   32'(mem_en),   32'(ph == 1));
      chk($sformatf("rnd%0d mem_we", c),   32'(mem_we),   32'(ph == 1 && cwe));
      chk($sformatf("rnd%0d if_valid", c), 32'(if_valid), 32'(e_ifv));
      chk($sformatf("rnd%0d dm_valid", c), 32'(dm_valid), 32'(e_dmv));
      chk($sformatf("rnd%0d if_stall", c), 32'(if_stall), 32'(if_req && !e_ifv));
      chk($sformatf("rnd%0d dm_stall", c), 32'(dm_stall), 32'(dm_req && !e_dmv));
      chk($sformatf("rnd%0d if_rdata", c), if_rdata, eifd);
      chk($sformatf("rnd%0d dm_rdata", c), dm_rdata, edmd);
      if (ph != 0) chk($sformatf("rnd%0d mem_addr", c), mem_addr, caddr);
      if (ph != 0 && own && cwe) chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, cwd);
      @(posedge clk);
      // advance the model with the requests present at this edge
      if (ph == 0) begin
        if (if_req || dm_req) begin
          own = (if_req && dm_req) ? !lst : dm_req;
          lst = own;
          ph  = 1;
          if (own) begin
            caddr = dm_addr; cwe = dm_we; cwd = dm_wdata; cdat = rd(dm_addr);
          end else begin
            caddr = if_addr; cwe = 1'b0; cdat = rd(if_addr);
          end
        end
      end else if (ph == LAT + 2) begin
        ph = 0;
      end else begin
        ph++;
        if (ph == LAT + 2) begin
          if (!own)     eifd = cdat;
          else if (!cwe) edmd = cdat;
        end
      end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
